w_stage_writeback_grf: RTL

//  Consumer end of the M->W pipeline register. Decodes the W-stage instruction word, then

---
 rtl/w_stage_writeback_grf_pkg.sv | 54 +++++
 rtl/w_stage_writeback_grf_grf_32x32.sv | 46 ++++
 rtl/w_stage_writeback_grf.sv | 121 ++++++++++++
 3 files changed

// File: rtl/w_stage_writeback_grf_pkg.sv
// Shared MIPS opcode/funct encodings and writeback helpers for the pipeline decoders.
package w_stage_writeback_grf_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_sel_e;
    typedef enum logic [1:0] {SRC_ALU, SRC_LOAD, SRC_PC8} wb_src_e;
    typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} load_kind_e;

    // Lane select plus extension for the aligned memory word; a[0] is ignored for halves.
    function automatic logic [31:0] load_extend(load_kind_e kind, logic [31:0] word,
                                                logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*a +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (kind)
            LD_B:    load_extend = {{24{b[7]}}, b};
            LD_BU:   load_extend = {24'd0, b};
            LD_H:    load_extend = {{16{h[15]}}, h};
            LD_HU:   load_extend = {16'd0, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/w_stage_writeback_grf_grf_32x32.sv
// 32x32 register file: synchronous write, two combinational read ports, optional write-first bypass.
module grf_32x32 #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data
);
    logic [31:0] regs_reg [32];
    logic [4:0]  raddr [2];
    logic [31:0] rdata [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_reg[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs_reg[waddr] <= wdata;
        end
    end

    assign raddr[0] = rs_addr;
    assign raddr[1] = rt_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            always_comb begin
                if (raddr[gi] == 5'd0)
                    rdata[gi] = '0;
                else if (BYPASS != 0 && we && raddr[gi] == waddr)
                    rdata[gi] = wdata;
                else
                    rdata[gi] = regs_reg[raddr[gi]];
            end
        end
    endgenerate

    assign rs_data = rdata[0];
    assign rt_data = rdata[1];
endmodule

// File: rtl/w_stage_writeback_grf.sv
// W stage: decode the retiring instruction, form the writeback tuple, commit it to the GRF
// and count retired instructions.
module w_stage_writeback_grf
    import w_stage_writeback_grf_pkg::*;
#(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      w_ir,
    input  logic [31:0]      w_pc4,
    input  logic [31:0]      w_ao,
    input  logic [31:0]      w_dr,
    input  logic [31:0]      w_pc8,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic             w_we,
    output logic [4:0]       w_waddr,
    output logic [31:0]      w_wdata,
    output logic [CNT_W-1:0] instret
);
    logic [5:0]       op;
    logic [5:0]       fn;
    logic             dec_write;
    dst_sel_e         dst_sel;
    wb_src_e          src;
    load_kind_e       ld_kind;
    logic [4:0]       dest;
    logic [31:0]      data;
    logic [CNT_W-1:0] instret_reg;
    logic             unused_bits;

    assign op = w_ir[31:26];
    assign fn = w_ir[5:0];
    // rs field, shamt and PC+4 play no part in writeback
    assign unused_bits = ^{w_pc4, w_ir[25:21], w_ir[10:6]};

    always_comb begin
        dec_write = 1'b0;
        dst_sel   = DST_RD;
        src       = SRC_ALU;
        ld_kind   = LD_W;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU,
                    FN_SLL, FN_SRL, FN_SRA: dec_write = 1'b1;
                    FN_JALR: begin
                        dec_write = 1'b1;
                        src       = SRC_PC8;
                    end
                    default: dec_write = 1'b0;
                endcase
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_SLTI, OP_SLTIU: begin
                dec_write = 1'b1;
                dst_sel   = DST_RT;
            end
            OP_JAL: begin
                dec_write = 1'b1;
                dst_sel   = DST_RA;
                src       = SRC_PC8;
            end
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                dec_write = 1'b1;
                dst_sel   = DST_RT;
                src       = SRC_LOAD;
                case (op)
                    OP_LB:   ld_kind = LD_B;
                    OP_LBU:  ld_kind = LD_BU;
                    OP_LH:   ld_kind = LD_H;
                    OP_LHU:  ld_kind = LD_HU;
                    default: ld_kind = LD_W;
                endcase
            end
            default: dec_write = 1'b0;
        endcase
    end

    always_comb begin
        case (dst_sel)
            DST_RT:  dest = w_ir[20:16];
            DST_RA:  dest = REG_RA;
            default: dest = w_ir[15:11];
        endcase
        case (src)
            SRC_LOAD: data = load_extend(ld_kind, w_dr, w_ao[1:0]);
            SRC_PC8:  data = w_pc8;
            default:  data = w_ao;
        endcase
    end

    // Writes to $0 are squashed here so the forward unit never sees them
    assign w_we    = dec_write && (dest != 5'd0);
    assign w_waddr = w_we ? dest : 5'd0;
    assign w_wdata = w_we ? data : 32'd0;

    grf_32x32 #(.BYPASS(BYPASS)) u_grf (
        .clk     (clk),
        .reset   (reset),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    always_ff @(posedge clk) begin
        if (reset)
            instret_reg <= '0;
        else if (w_ir != 32'd0)
            instret_reg <= instret_reg + 1'b1;
    end

    assign instret = instret_reg;
endmodule
